// File: rtl/d_buf_pkg.sv
// ---------------------------------------------------------------------------
// d_buf_pkg
// Shared definitions for the d_unbuf frame unbuffer and its bank RAM:
// default bank depth / address width, word and byte widths, and the
// reader FSM state type.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package d_buf_pkg;

  localparam int DEPTH_DEF = 256;
  localparam int AW_DEF    = 8;
  localparam int WORD_W    = 16;
  localparam int BYTE_W    = 8;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/dpram_16xd.sv
// ---------------------------------------------------------------------------
// dpram_16xd
// One DEPTH x 16 bank: a single write port and a single read port whose
// output is registered (data appears one cycle after raddr/re).
// Ports:
//   clk    - clock
//   we     - write enable; wdata is stored at waddr
//   waddr  - write word address
//   wdata  - write word
//   re     - read enable; rdata updates from raddr on the next edge
//   raddr  - read word address
//   rdata  - registered read word (holds when re is low)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module dpram_16xd
  import d_buf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/d_unbuf.sv
// ---------------------------------------------------------------------------
// d_unbuf
// Ping-pong frame unbuffer. 16-bit words arriving as a data_v framed burst
// are written into one of two banks; a reader drains full banks in
// acceptance order as a stream of bytes (two per word).
// Ports:
//   clk       - single clock
//   rst       - synchronous active-high reset
//   data_in   - 16-bit write word, sampled while data_v is high
//   data_v    - frame valid; frame ends on its falling edge
//   data_out  - read byte
//   data_ov   - data_out valid
//   ovf_err   - one-cycle pulse: frame discarded (both banks busy)
//   trunc_err - one-cycle pulse: frame longer than DEPTH words
// Build option:
//   D_UNBUF_BYTE_SWAP_EN - when defined, the high byte of each word is
//   emitted first; otherwise the low byte is first.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module d_unbuf
  import d_buf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_v,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_ov,
  output logic              ovf_err,
  output logic              trunc_err
);

  // writer state
  logic          data_v_q;
  logic          armed_q;     // data_v has been seen low since reset
  logic          acc_q;       // current frame accepted
  logic          rej_q;       // current frame rejected
  logic          trunc_q;     // trunc_err already raised for this frame
  logic          w_sel_q;
  logic [AW:0]   wr_cnt_q;
  logic [1:0]    full_q, full_d;
  logic [AW:0]   len_q [2];
  logic          ovf_err_q, trunc_err_q;

  // reader state
  rd_state_e     state_q, state_d;
  logic [AW:0]   byte_cnt_q, byte_cnt_d;
  logic          r_sel_q;
  logic          rd_en, rd_last;
  logic          rd_v_q, rd_sel_q, rd_bank_q;
  logic [BYTE_W-1:0] data_out_q;
  logic          data_ov_q;

  logic          frame_start, frame_end, accept, in_acc;
  logic          wr_ok, drop, set_full, bank_free;
  logic [AW:0]   wr_idx;
  logic [AW+1:0] last_byte;
  logic [WORD_W-1:0] bank_rdata [2];
  logic [WORD_W-1:0] rd_word;
  logic [BYTE_W-1:0] rd_byte;

  // ---------------- writer ----------------
  assign frame_start = data_v & ~data_v_q & armed_q;
  assign frame_end   = ~data_v & data_v_q;
  // the reader releasing bank w_sel in this very cycle frees it for a new frame
  assign bank_free   = ~full_q[w_sel_q] | (rd_last & (r_sel_q == w_sel_q));
  assign accept      = frame_start & bank_free;
  assign in_acc      = accept | (acc_q & data_v);
  assign wr_idx      = accept ? '0 : wr_cnt_q;
  // wr_idx[AW] set means the bank is already holding DEPTH words
  assign wr_ok       = in_acc & ~wr_idx[AW];
  assign drop        = in_acc &  wr_idx[AW];
  assign set_full    = frame_end & acc_q;

  always_comb begin
    full_d = full_q;
    if (set_full) full_d[w_sel_q] = 1'b1;
    if (rd_last)  full_d[r_sel_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_v_q    <= 1'b0;
      armed_q     <= 1'b0;
      acc_q       <= 1'b0;
      rej_q       <= 1'b0;
      trunc_q     <= 1'b0;
      w_sel_q     <= 1'b0;
      wr_cnt_q    <= '0;
      full_q      <= '0;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      ovf_err_q   <= 1'b0;
      trunc_err_q <= 1'b0;
    end else begin
      data_v_q    <= data_v;
      if (!data_v) armed_q <= 1'b1;
      ovf_err_q   <= frame_end & rej_q;
      trunc_err_q <= drop & ~trunc_q;
      full_q      <= full_d;
      if (frame_start) begin
        acc_q   <= accept;
        rej_q   <= ~accept;
        trunc_q <= 1'b0;
      end else if (frame_end) begin
        acc_q <= 1'b0;
        rej_q <= 1'b0;
      end
      if (drop) trunc_q <= 1'b1;
      if (wr_ok) wr_cnt_q <= wr_idx + (AW+1)'(1);
      if (set_full) begin
        len_q[w_sel_q] <= wr_cnt_q;
        w_sel_q        <= ~w_sel_q;
        wr_cnt_q       <= '0;
      end
    end
  end

  // ---------------- banks ----------------
  for (genvar b = 0; b < 2; b++) begin : g_bank
    dpram_16xd #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_ram (
      .clk   (clk),
      .we    (wr_ok && (w_sel_q == 1'(b))),
      .waddr (wr_idx[AW-1:0]),
      .wdata (data_in),
      .re    (rd_en && (r_sel_q == 1'(b))),
      .raddr (byte_cnt_q[AW:1]),
      .rdata (bank_rdata[b])
    );
  end

  // ---------------- reader ----------------
  assign last_byte = {len_q[r_sel_q], 1'b0} - (AW+2)'(1);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    rd_en      = 1'b0;
    rd_last    = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        // look ahead at a bank being filled this cycle so the first
        // address goes out on the cycle right after the frame end
        if (full_q[r_sel_q] || (set_full && (w_sel_q == r_sel_q))) begin
          state_d    = RD_READ;
          byte_cnt_d = '0;
        end
      end
      RD_READ: begin
        rd_en = 1'b1;
        if ({1'b0, byte_cnt_q} == last_byte) begin
          rd_last = 1'b1;
          state_d = RD_IDLE;
        end else begin
          byte_cnt_d = byte_cnt_q + (AW+1)'(1);
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign rd_word = bank_rdata[rd_bank_q];
`ifdef D_UNBUF_BYTE_SWAP_EN
  assign rd_byte = rd_sel_q ? rd_word[7:0] : rd_word[15:8];
`else
  assign rd_byte = rd_sel_q ? rd_word[15:8] : rd_word[7:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RD_IDLE;
      byte_cnt_q <= '0;
      r_sel_q    <= 1'b0;
      rd_v_q     <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_bank_q  <= 1'b0;
      data_out_q <= '0;
      data_ov_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      if (rd_last) r_sel_q <= ~r_sel_q;
      rd_v_q     <= rd_en;
      rd_sel_q   <= byte_cnt_q[0];
      rd_bank_q  <= r_sel_q;
      data_ov_q  <= rd_v_q;
      if (rd_v_q) data_out_q <= rd_byte;
    end
  end

  assign data_out  = data_out_q;
  assign data_ov   = data_ov_q;
  assign ovf_err   = ovf_err_q;
  assign trunc_err = trunc_err_q;

endmodule

// File: tb/tb_d_unbuf.sv
`timescale 1ns/1ps
module tb_d_unbuf;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        data_v;
  logic [7:0]  data_out;
  logic        data_ov, ovf_err, trunc_err;

  d_unbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_v    (data_v),
    .data_out  (data_out),
    .data_ov   (data_ov),
    .ovf_err   (ovf_err),
    .trunc_err (trunc_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // scoreboard
  logic [7:0]  exp_b[$];
  int          exp_t[$];
  int          exp_ovf[$];
  int          exp_tr[$];
  // reference model: last read-address cycle of each accepted, unfinished frame
  int          busy_q[$];
  int          last_prev = -100;
  logic [15:0] wbuf[$];
  bit          mon_en = 1'b0;

  function automatic void check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endfunction

  function automatic logic [7:0] pick(input logic [15:0] w, input int j);
`ifdef D_UNBUF_BYTE_SWAP_EN
    return (j % 2 == 0) ? w[15:8] : w[7:0];
`else
    return (j % 2 == 0) ? w[7:0] : w[15:8];
`endif
  endfunction

  // monitor
  logic [7:0] mon_b;
  int         mon_t;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (data_ov === 1'b1) begin
        if (exp_b.size() == 0) check("unexpected_byte", 1, 0);
        else begin
          mon_b = exp_b.pop_front();
          mon_t = exp_t.pop_front();
          check("byte_value", int'(data_out), int'(mon_b));
          check("byte_cycle", cyc, mon_t);
        end
      end
      if (ovf_err === 1'b1) begin
        if (exp_ovf.size() == 0) check("unexpected_ovf", 1, 0);
        else check("ovf_cycle", cyc, exp_ovf.pop_front());
      end
      if (trunc_err === 1'b1) begin
        if (exp_tr.size() == 0) check("unexpected_trunc", 1, 0);
        else check("trunc_cycle", cyc, exp_tr.pop_front());
      end
    end
  end

  // Drive the words in wbuf as one frame, then keep data_v low for gap cycles
  // (the frame-end cycle included). Expectations come from the frame timeline:
  // the reader issues its first address one cycle after the frame end (or two
  // cycles after the previous frame's last address), one byte per cycle, and
  // output lags the address by two cycles.
  task automatic send_frame(input int gap);
    int  s, e, n, neff, first;
    bit  acc;
    n = wbuf.size();
    acc = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      data_v  = 1'b1;
      data_in = wbuf[i];
      if (i == 0) begin
        s = cyc;
        while (busy_q.size() != 0 && busy_q[0] <= s) void'(busy_q.pop_front());
        acc = (busy_q.size() < 2);
      end
      if (acc && i == DEPTH) exp_tr.push_back(s + DEPTH + 1);
    end
    @(posedge clk); #1;
    data_v  = 1'b0;
    data_in = 16'($urandom);
    e = cyc;
    if (acc) begin
      neff  = (n > DEPTH) ? DEPTH : n;
      first = (e + 1 > last_prev + 2) ? e + 1 : last_prev + 2;
      for (int j = 0; j < 2 * neff; j++) begin
        exp_b.push_back(pick(wbuf[j / 2], j));
        exp_t.push_back(first + 2 + j);
      end
      last_prev = first + 2 * neff - 1;
      busy_q.push_back(last_prev);
    end else begin
      exp_ovf.push_back(e + 1);
    end
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic fill_random(input int n);
    wbuf.delete();
    for (int i = 0; i < n; i++) wbuf.push_back(16'($urandom));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_b.size() + exp_ovf.size() + exp_tr.size()) != 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    check("pending_after_drain", exp_b.size() + exp_ovf.size() + exp_tr.size(), 0);
    repeat (5) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    data_v  = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_ov",   int'(data_ov),   0);
    check("rst_data_out",  int'(data_out),  0);
    check("rst_ovf_err",   int'(ovf_err),   0);
    check("rst_trunc_err", int'(trunc_err), 0);
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);

    // three-word directed frame
    wbuf.delete();
    wbuf.push_back(16'h1122);
    wbuf.push_back(16'h3344);
    wbuf.push_back(16'h5566);
    send_frame(4);
    drain();

    // three back-to-back full-depth frames; the third finds both banks busy
    for (int f = 0; f < 3; f++) begin
      fill_random(DEPTH);
      send_frame(1);
    end
    check("third_frame_rejected", exp_ovf.size(), 1);
    drain();

    // oversize frame is truncated to DEPTH words
    fill_random(300);
    send_frame(3);
    drain();

    // reset in the middle of a read
    fill_random(100);
    send_frame(1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("busy_before_rst", int'(data_ov), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_b.delete();
    exp_t.delete();
    exp_ovf.delete();
    exp_tr.delete();
    busy_q.delete();
    last_prev = -100;
    @(negedge clk);
    check("data_ov_after_rst", int'(data_ov), 0);
    repeat (2) @(posedge clk);
    fill_random(2);
    send_frame(3);
    drain();

    // single-word frames every four cycles
    for (int f = 0; f < 1000; f++) begin
      fill_random(1);
      send_frame(3);
    end
    check("no_ovf_single_words", exp_ovf.size(), 0);
    drain();

    // random frame lengths and gaps
    for (int f = 0; f < 150; f++) begin
      int n, gap;
      n   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(250, 262))
                                         : int'($urandom_range(1, 24));
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60))
                                        : int'($urandom_range(1, 6));
      fill_random(n);
      send_frame(gap);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/d_unbuf.md
D_UNBUF -- requirements
Module: d_unbuf

Interface
REQ-001 Parameter DEPTH, default 256, words per bank (power of two, 2..1024).
REQ-002 Parameter AW, default 8, word-address width, equal to log2(DEPTH).
REQ-003 Port clk, input, 1: single clock for all logic.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port data_in, input, 16: write word, sampled while data_v is high.
REQ-006 Port data_v, input, 1: frame-valid; one word per cycle while high, frame ends on its falling edge.
REQ-007 Port data_out, output, 8: read byte.
REQ-008 Port data_ov, output, 1: data_out valid this cycle.
REQ-009 Port ovf_err, output, 1: one-cycle pulse, frame discarded.
REQ-010 Port trunc_err, output, 1: one-cycle pulse, frame exceeded DEPTH words.

Function
REQ-011 Two banks of DEPTH x 16, ping-pong: the writer fills bank w_sel while the reader drains bank r_sel.
REQ-012 Frame start is data_v high with the previous-cycle data_v low; the frame is accepted only if bank w_sel is not full at that cycle, where a release in the same cycle counts as free.
REQ-013 For an accepted frame: word k is written to address k, and the word count is kept in an AW+1-bit length register.
REQ-014 Words beyond DEPTH are dropped; trunc_err pulses on the first dropped word; length saturates at DEPTH.
REQ-015 On the frame-end cycle (data_v low, previous-cycle data_v high) of an accepted frame: the bank is marked full with its length, w_sel toggles, and the write address clears to 0.
REQ-016 A rejected frame writes nothing, does not toggle w_sel, and pulses ovf_err on its frame-end cycle.
REQ-017 Reader FSM has two states: IDLE and READ.
REQ-018 IDLE to READ when bank r_sel is full; the byte counter clears to 0.
REQ-019 In READ, the byte counter runs 0 .. 2*length-1, one per cycle; word address is byte_cnt[AW:1] and byte_cnt[0] selects the byte.
REQ-020 Byte order: low byte first (byte_cnt[0]=0 gives data_in[7:0]).
REQ-021 Bank read is registered (1 cycle) and data_out is registered (1 cycle), so data_ov and data_out appear 2 cycles after the address is issued.
REQ-022 data_ov is high for exactly 2*length contiguous cycles per frame.
REQ-023 On the cycle the last byte address is issued, the bank's full flag clears, r_sel toggles, and the FSM returns to IDLE; a following frame's output starts no earlier than 1 idle cycle later.
REQ-024 Full flags are set only by the writer and cleared only by the reader; a set and a clear in the same cycle apply to different banks by construction.
REQ-025 Frames are emitted in acceptance order; both banks may be full simultaneously.

Reset
REQ-026 On rst high at a clock edge the following clear to 0: w_sel, r_sel, write address, byte counter, both full flags, both lengths, delayed data_v, data_out, data_ov, ovf_err and trunc_err; the FSM goes to IDLE.
REQ-027 Reset asserted mid-frame or mid-read abandons all buffered data with no further output; bank contents are not cleared.
REQ-028 A frame already in progress when rst deasserts (data_v high) is ignored until data_v next falls.

Configuration
REQ-029 Macro D_UNBUF_BYTE_SWAP_EN: when defined, byte order is high byte first (byte_cnt[0]=0 gives data_in[15:8]).
REQ-030 When D_UNBUF_BYTE_SWAP_EN is undefined, byte order is low byte first per REQ-020; latency and all other behaviour are identical in both builds.

Structure
REQ-031 Shared package d_buf_pkg holds: the DEPTH and AW defaults, the word width (16) and byte width (8) constants, and the reader FSM state enum.
REQ-032 Sub-module dpram_16xd is one bank: 1 write port, 1 registered read port, parameterised by DEPTH; it is instantiated twice.

Verification
REQ-033 Single frame of 3 words 0x1122, 0x3344, 0x5566 -> data_ov high for 6 cycles; data_out is 22,11,44,33,66,55; the first byte appears 3 cycles after the frame-end cycle.
REQ-034 Same frame built with D_UNBUF_BYTE_SWAP_EN -> data_out is 11,22,33,44,55,66.
REQ-035 Three back-to-back 256-word frames with 1-cycle gaps -> frames 1 and 2 are output in order with 512 bytes each; frame 3 is discarded with a single ovf_err pulse.
REQ-036 A 300-word frame -> trunc_err pulses once at word 256; exactly 512 bytes are output.
REQ-037 rst asserted for 1 cycle midway through reading a 100-word frame -> data_ov low the next cycle; a subsequent 2-word frame outputs 4 correct bytes from bank 0.
REQ-038 1-word frames every 4 cycles for 1000 frames -> each outputs 2 bytes, with no ovf_err and no loss.
